// File: rtl/kmc_brg_pkg.sv
// Shared types for the KMC branch register: op codes, sequencer states and
// the microcode field decode reused by the CRAM decoder.
package kmc_brg_pkg;

    typedef enum logic [2:0] {
        BRG_NOP  = 3'd0,
        BRG_LOAD = 3'd1,
        BRG_RORD = 3'd2,
        BRG_SHR1 = 3'd3,
        BRG_SHL1 = 3'd4,
        BRG_ASR1 = 3'd5,
        BRG_RORN = 3'd6,
        BRG_SHRN = 3'd7
    } brg_op_t;

    typedef enum logic {
        BRG_IDLE  = 1'b0,
        BRG_SHIFT = 1'b1
    } brg_state_t;

    // A cleared write-enable bit in the microword forces NOP regardless of the select field.
    function automatic brg_op_t brg_op_decode(input logic brg_wr, input logic [2:0] brg_sel);
        return brg_wr ? brg_op_t'(brg_sel) : BRG_NOP;
    endfunction

endpackage

// File: rtl/kmc_brg_shift1.sv
// Combinational one-step BRG shifter, shared by the single-step ops and
// every step of the multi-cycle RORN/SHRN sequence.
module kmc_brg_shift1
    import kmc_brg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  brg_op_t          op,
    input  logic [WIDTH-1:0] value,
    input  logic             cin,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    always_comb begin
        result = value;
        cout   = 1'b0;
        case (op)
            BRG_LOAD: result = din;
            BRG_RORD: result = {din[0], din[WIDTH-1:1]};
            BRG_SHR1, BRG_SHRN: begin
                result = {cin, value[WIDTH-1:1]};
                cout   = value[0];
            end
            BRG_SHL1: begin
                result = {value[WIDTH-2:0], cin};
                cout   = value[WIDTH-1];
            end
            BRG_ASR1: begin
                result = {value[WIDTH-1], value[WIDTH-1:1]};
                cout   = value[0];
            end
            BRG_RORN: begin
                result = {value[0], value[WIDTH-1:1]};
                cout   = value[0];
            end
            default: begin
                result = value;
                cout   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/kmc_brg_seq.sv
// KMC branch register with legacy moves, single-step shifts and a
// clken-sequenced shift-by-N engine with busy/done handshake.
module kmc_brg_seq
    import kmc_brg_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             clken,
    input  brg_op_t          op,
    input  logic [CNTW-1:0]  cnt,
    input  logic [WIDTH-1:0] din,
    input  logic             cin,
    output logic [WIDTH-1:0] brg,
    output logic             cout,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             msb,
    output logic             lsb
);

    brg_state_t       state, state_d;
    brg_op_t          op_q, op_q_d, sh_op;
    logic [CNTW-1:0]  rem, rem_d;
    logic [WIDTH-1:0] brg_d, sh_val;
    logic             cout_d, busy_d, done_d, sh_cout;

    // While sequencing, the shifter follows the op latched at issue, not the live op port.
    assign sh_op = (state == BRG_SHIFT) ? op_q : op;

    kmc_brg_shift1 #(.WIDTH(WIDTH)) u_shift1 (
        .op     (sh_op),
        .value  (brg),
        .cin    (cin),
        .din    (din),
        .result (sh_val),
        .cout   (sh_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || init) begin
            state <= BRG_IDLE;
            op_q  <= BRG_NOP;
            rem   <= '0;
            brg   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            op_q  <= op_q_d;
            rem   <= rem_d;
            brg   <= brg_d;
            cout  <= cout_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        op_q_d  = op_q;
        rem_d   = rem;
        brg_d   = brg;
        cout_d  = cout;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state)
            BRG_IDLE: begin
                if (clken) begin
                    case (op)
                        BRG_LOAD, BRG_RORD: brg_d = sh_val;
                        BRG_SHR1, BRG_SHL1, BRG_ASR1: begin
                            brg_d  = sh_val;
                            cout_d = sh_cout;
                        end
                        BRG_RORN, BRG_SHRN: begin
                            if (cnt == '0) begin
                                done_d = 1'b1;
                            end else begin
                                rem_d   = cnt;
                                op_q_d  = op;
                                busy_d  = 1'b1;
                                state_d = BRG_SHIFT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            BRG_SHIFT: begin
                if (clken) begin
                    brg_d  = sh_val;
                    cout_d = sh_cout;
                    rem_d  = rem - CNTW'(1);
                    if (rem == CNTW'(1)) begin
                        state_d = BRG_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = BRG_IDLE;
        endcase
    end

    assign zero = (brg == '0);
    assign msb  = brg[WIDTH-1];
    assign lsb  = brg[0];

endmodule

// File: tb/tb_kmc_brg_seq.sv
// Scoreboard bench for kmc_brg_seq at WIDTH=8 and WIDTH=16 with directed vectors.
module tb_kmc_brg_seq;
    import kmc_brg_pkg::*;

    typedef struct {
        int         id;
        bit         sel16;
        logic [15:0] brg;
        logic       cout;
        logic       busy;
        logic       done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, init, clken, cin;
    brg_op_t     op;
    logic [4:0]  cnt;
    logic [15:0] din;

    logic [7:0]  brg8;
    logic        cout8, busy8, done8, zero8, msb8, lsb8;
    logic [15:0] brg16;
    logic        cout16, busy16, done16, zero16, msb16, lsb16;

    exp_t q[$];
    int   total = 0;
    int   passed = 0;
    int   vec_id = 0;

    always #5 clk = ~clk;

    kmc_brg_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .init(init), .clken(clken), .op(op),
        .cnt(cnt[3:0]), .din(din[7:0]), .cin(cin),
        .brg(brg8), .cout(cout8), .busy(busy8), .done(done8),
        .zero(zero8), .msb(msb8), .lsb(lsb8)
    );

    kmc_brg_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .init(init), .clken(clken), .op(op),
        .cnt(cnt), .din(din), .cin(cin),
        .brg(brg16), .cout(cout16), .busy(busy16), .done(done16),
        .zero(zero16), .msb(msb16), .lsb(lsb16)
    );

    task automatic chk(input int id, input string what, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL vec%0d %s: got %h expected %h", id, what, act, exp);
    endtask

    // Monitor: after each active edge, compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.sel16) begin
                    chk(e.id, "brg",  brg16, e.brg);
                    chk(e.id, "cout", {15'b0, cout16}, {15'b0, e.cout});
                    chk(e.id, "busy", {15'b0, busy16}, {15'b0, e.busy});
                    chk(e.id, "done", {15'b0, done16}, {15'b0, e.done});
                    chk(e.id, "zero", {15'b0, zero16}, {15'b0, (e.brg == 16'h0)});
                    chk(e.id, "msb",  {15'b0, msb16},  {15'b0, e.brg[15]});
                    chk(e.id, "lsb",  {15'b0, lsb16},  {15'b0, e.brg[0]});
                end else begin
                    chk(e.id, "brg",  {8'h0, brg8}, e.brg);
                    chk(e.id, "cout", {15'b0, cout8}, {15'b0, e.cout});
                    chk(e.id, "busy", {15'b0, busy8}, {15'b0, e.busy});
                    chk(e.id, "done", {15'b0, done8}, {15'b0, e.done});
                    chk(e.id, "zero", {15'b0, zero8}, {15'b0, (e.brg[7:0] == 8'h0)});
                    chk(e.id, "msb",  {15'b0, msb8},  {15'b0, e.brg[7]});
                    chk(e.id, "lsb",  {15'b0, lsb8},  {15'b0, e.brg[0]});
                end
            end
        end
    end

    task automatic step(input bit sel16, input logic r_n, input logic in_init, input logic en,
                        input brg_op_t o, input logic [4:0] c, input logic [15:0] d, input logic ci,
                        input logic [15:0] eb, input logic ec, input logic ebusy, input logic edone);
        exp_t e;
        @(negedge clk);
        rst_n = r_n; init = in_init; clken = en; op = o; cnt = c; din = d; cin = ci;
        vec_id++;
        e.id = vec_id; e.sel16 = sel16; e.brg = eb; e.cout = ec; e.busy = ebusy; e.done = edone;
        q.push_back(e);
    endtask

    // Shorthand for a normal (no reset) vector.
    task automatic op_step(input bit sel16, input logic en, input brg_op_t o, input logic [4:0] c,
                           input logic [15:0] d, input logic ci,
                           input logic [15:0] eb, input logic ec, input logic ebusy, input logic edone);
        step(sel16, 1'b1, 1'b0, en, o, c, d, ci, eb, ec, ebusy, edone);
    endtask

    logic [7:0]  shrn_tbl [0:7] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    logic [15:0] rot;

    initial begin
        rst_n = 1'b0; init = 1'b0; clken = 1'b0; op = BRG_NOP; cnt = '0; din = '0; cin = 1'b0;

        // Reset and init after a load
        step   (0, 1'b0, 1'b0, 1'b1, BRG_NOP,  5'd0, 16'h0000, 1'b0, 16'h00, 1'b0, 1'b0, 1'b0);
        op_step(0, 1'b1, BRG_LOAD, 5'd0, 16'h00A5, 1'b0, 16'hA5, 1'b0, 1'b0, 1'b0);
        step   (0, 1'b0, 1'b0, 1'b1, BRG_LOAD, 5'd0, 16'h00FF, 1'b0, 16'h00, 1'b0, 1'b0, 1'b0);
        op_step(0, 1'b1, BRG_LOAD, 5'd0, 16'h00A5, 1'b0, 16'hA5, 1'b0, 1'b0, 1'b0);
        step   (0, 1'b1, 1'b1, 1'b1, BRG_LOAD, 5'd0, 16'h00FF, 1'b0, 16'h00, 1'b0, 1'b0, 1'b0);

        // Legacy moves and clken gating
        op_step(0, 1'b1, BRG_LOAD, 5'd0, 16'h003C, 1'b0, 16'h3C, 1'b0, 1'b0, 1'b0);
        op_step(0, 1'b1, BRG_RORD, 5'd0, 16'h0081, 1'b0, 16'hC0, 1'b0, 1'b0, 1'b0);
        op_step(0, 1'b0, BRG_LOAD, 5'd0, 16'h0055, 1'b0, 16'hC0, 1'b0, 1'b0, 1'b0);
        op_step(0, 1'b0, BRG_RORD, 5'd0, 16'h0055, 1'b0, 16'hC0, 1'b0, 1'b0, 1'b0);

        // Single-step shifts
        op_step(0, 1'b1, BRG_LOAD, 5'd0, 16'h0081, 1'b0, 16'h81, 1'b0, 1'b0, 1'b0);
        op_step(0, 1'b1, BRG_SHR1, 5'd0, 16'h0000, 1'b1, 16'hC0, 1'b1, 1'b0, 1'b0);
        op_step(0, 1'b1, BRG_LOAD, 5'd0, 16'h0081, 1'b0, 16'h81, 1'b1, 1'b0, 1'b0);
        op_step(0, 1'b1, BRG_SHL1, 5'd0, 16'h0000, 1'b0, 16'h02, 1'b1, 1'b0, 1'b0);
        op_step(0, 1'b1, BRG_LOAD, 5'd0, 16'h0080, 1'b0, 16'h80, 1'b1, 1'b0, 1'b0);
        op_step(0, 1'b1, BRG_ASR1, 5'd0, 16'h0000, 1'b0, 16'hC0, 1'b0, 1'b0, 1'b0);

        // RORN cnt=3 with one stalled cycle; a LOAD during busy is ignored
        op_step(0, 1'b1, BRG_LOAD, 5'd0, 16'h0001, 1'b0, 16'h01, 1'b0, 1'b0, 1'b0);
        op_step(0, 1'b1, BRG_RORN, 5'd3, 16'h0000, 1'b0, 16'h01, 1'b0, 1'b1, 1'b0);
        op_step(0, 1'b0, BRG_NOP,  5'd0, 16'h0000, 1'b0, 16'h01, 1'b0, 1'b1, 1'b0);
        op_step(0, 1'b1, BRG_NOP,  5'd0, 16'h0000, 1'b0, 16'h80, 1'b1, 1'b1, 1'b0);
        op_step(0, 1'b1, BRG_LOAD, 5'd0, 16'h00FF, 1'b0, 16'h40, 1'b0, 1'b1, 1'b0);
        op_step(0, 1'b1, BRG_NOP,  5'd0, 16'h0000, 1'b0, 16'h20, 1'b0, 1'b0, 1'b1);
        op_step(0, 1'b1, BRG_NOP,  5'd0, 16'h0000, 1'b0, 16'h20, 1'b0, 1'b0, 1'b0);

        // SHRN cnt=0: done next cycle, never busy
        op_step(0, 1'b1, BRG_SHRN, 5'd0, 16'h0000, 1'b1, 16'h20, 1'b0, 1'b0, 1'b1);
        op_step(0, 1'b1, BRG_NOP,  5'd0, 16'h0000, 1'b1, 16'h20, 1'b0, 1'b0, 1'b0);

        // SHRN cnt=9 with cin=1 from zero: fills beyond WIDTH
        op_step(0, 1'b1, BRG_LOAD, 5'd0, 16'h0000, 1'b0, 16'h00, 1'b0, 1'b0, 1'b0);
        op_step(0, 1'b1, BRG_SHRN, 5'd9, 16'h0000, 1'b1, 16'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            op_step(0, 1'b1, BRG_NOP, 5'd0, 16'h0000, 1'b1, {8'h0, shrn_tbl[i]}, 1'b0, 1'b1, 1'b0);
        op_step(0, 1'b1, BRG_NOP,  5'd0, 16'h0000, 1'b1, 16'hFF, 1'b1, 1'b0, 1'b1);
        op_step(0, 1'b1, BRG_NOP,  5'd0, 16'h0000, 1'b1, 16'hFF, 1'b1, 1'b0, 1'b0);

        // init mid-RORN aborts without a done pulse
        op_step(0, 1'b1, BRG_LOAD, 5'd0, 16'h0001, 1'b0, 16'h01, 1'b1, 1'b0, 1'b0);
        op_step(0, 1'b1, BRG_RORN, 5'd5, 16'h0000, 1'b0, 16'h01, 1'b1, 1'b1, 1'b0);
        op_step(0, 1'b1, BRG_NOP,  5'd0, 16'h0000, 1'b0, 16'h80, 1'b1, 1'b1, 1'b0);
        op_step(0, 1'b1, BRG_NOP,  5'd0, 16'h0000, 1'b0, 16'h40, 1'b0, 1'b1, 1'b0);
        step   (0, 1'b1, 1'b1, 1'b1, BRG_NOP, 5'd0, 16'h0000, 1'b0, 16'h00, 1'b0, 1'b0, 1'b0);
        op_step(0, 1'b1, BRG_NOP,  5'd0, 16'h0000, 1'b0, 16'h00, 1'b0, 1'b0, 1'b0);
        op_step(0, 1'b1, BRG_SHL1, 5'd0, 16'h0000, 1'b1, 16'h01, 1'b0, 1'b0, 1'b0);

        // WIDTH=16: RORN cnt=17 on 16'h0001 ends at 16'h8000
        step   (1, 1'b0, 1'b0, 1'b1, BRG_NOP,  5'd0,  16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        op_step(1, 1'b1, BRG_LOAD, 5'd0,  16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
        op_step(1, 1'b1, BRG_RORN, 5'd17, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0);
        rot = 16'h0001;
        for (int i = 1; i <= 16; i++) begin
            rot = {rot[0], rot[15:1]};
            op_step(1, 1'b1, BRG_NOP, 5'd0, 16'h0000, 1'b0, rot, (i == 1), 1'b1, 1'b0);
        end
        op_step(1, 1'b1, BRG_NOP,  5'd0, 16'h0000, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);
        op_step(1, 1'b1, BRG_NOP,  5'd0, 16'h0000, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0);
        op_step(1, 1'b1, BRG_ASR1, 5'd0, 16'h0000, 1'b1, 16'hC000, 1'b0, 1'b0, 1'b0);
        op_step(1, 1'b1, BRG_SHL1, 5'd0, 16'h0000, 1'b1, 16'h8001, 1'b1, 1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
